// File: rtl/seqdet_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seqdet_frame_arbiter
// Purpose  : Time-shares one serial pattern detector between NCH bit-stream
//            requesters. Round-robin grant, one FRAME_LEN-bit frame per
//            grant, detector history cleared at every frame start. Each
//            finished frame reports its owning channel and match count.
// Options  : SEQDET_TIMEOUT_EN - when defined, a frame whose granted channel
//            stays idle for TMO cycles is ended early with aborted=1.
// Revision : 1.0 - initial release
// ============================================================================
module seqdet_frame_arbiter #(
  parameter int              NCH       = 4,
  parameter int              PLEN      = 4,
  parameter logic [PLEN-1:0] PATTERN   = 4'b1001,
  parameter int              FRAME_LEN = 16,
  parameter int              CNTW      = 5,
  parameter int              TMO       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         din,
  input  logic [NCH-1:0]         din_valid,
  output logic [NCH-1:0]         gnt,
  output logic                   busy,
  output logic                   match,
  output logic                   done,
  output logic [$clog2(NCH)-1:0] done_ch,
  output logic [CNTW-1:0]        match_cnt,
  output logic                   aborted
);

  localparam int               CHW         = $clog2(NCH);
  localparam int               BCW         = $clog2(FRAME_LEN + 1);
  localparam logic [CHW:0]     NCH_EXT     = (CHW + 1)'(NCH);
  localparam logic [CHW-1:0]   LAST_CH     = CHW'(NCH - 1);
  localparam logic [BCW-1:0]   LAST_BIT    = BCW'(FRAME_LEN - 1);
  localparam logic [BCW-1:0]   FIRST_CHECK = BCW'(PLEN - 1);
  localparam logic [CNTW-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [CHW-1:0]  rr_ptr;
  logic [CHW-1:0]  ch;
  logic [PLEN-2:0] hist;
  logic [BCW-1:0]  bitcnt;
  logic [CNTW-1:0] cnt;

  logic [NCH-1:0]  req_rot;
  logic            pick_found;
  logic [CHW:0]    pick_sum;
  logic [CHW-1:0]  pick_ch;

  logic            accept;
  logic [PLEN-1:0] window;
  logic            hit;
  logic [CNTW-1:0] cnt_next;
  logic            last_bit;
  logic            req_lost;
  logic            tmo_hit;
  logic            frame_end;
  logic            abort_now;

  // Requests rotated so that bit 0 is the channel under the rr pointer
  assign req_rot = NCH'({req, req} >> rr_ptr);

  // First requester at or after the rr pointer, wrapping back to channel 0
  always_comb begin
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (CHW + 1)'(i);
      end
    end
    if (pick_sum >= NCH_EXT) begin
      pick_sum = pick_sum - NCH_EXT;
    end
    pick_ch = pick_sum[CHW-1:0];
  end

  // Only the granted channel's bit stream reaches the detector, and only in RUN
  assign accept   = (state == S_RUN) && din_valid[ch];
  assign window   = {hist, din[ch]};
  assign hit      = accept && (window == PATTERN) && (bitcnt >= FIRST_CHECK);
  assign cnt_next = (hit && (cnt != CNT_MAX)) ? cnt + CNTW'(1) : cnt;
  assign last_bit = accept && (bitcnt == LAST_BIT);
  assign req_lost = !req[ch];

`ifdef SEQDET_TIMEOUT_EN
  localparam int             TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);

  logic [TW-1:0] idle_cnt;

  // Cycles since the last accepted bit (GRANT counts as a fresh start), so the
  // frame ends exactly TMO cycles after the last accepted bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if ((state == S_GRANT) || accept) begin
      idle_cnt <= TW'(1);
    end else if (state == S_RUN) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state == S_RUN) && !din_valid[ch] && (idle_cnt == TMO_LAST);
`else
  // TMO only matters with the idle timeout; keep the parameter referenced
  logic tmo_unused;
  assign tmo_unused = ^32'(TMO);
  assign tmo_hit    = 1'b0;
`endif

  // Next-state decode plus the frame-end controls used by the datapath
  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    abort_now  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        if (last_bit || req_lost || tmo_hit) begin
          state_next = S_DONE;
          frame_end  = 1'b1;
          // A frame that just took its final bit is complete, not aborted
          abort_now  = !last_bit;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant, detector history, counters and the registered frame report
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      ch        <= '0;
      gnt       <= '0;
      hist      <= '0;
      bitcnt    <= '0;
      cnt       <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
      done_ch   <= '0;
      match_cnt <= '0;
      aborted   <= 1'b0;
    end else begin
      match   <= hit;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            ch  <= pick_ch;
            gnt <= NCH'(1) << pick_ch;
          end
        end
        S_GRANT: begin
          hist   <= '0;
          bitcnt <= '0;
          cnt    <= '0;
        end
        S_RUN: begin
          if (accept) begin
            hist   <= window[PLEN-2:0];
            bitcnt <= bitcnt + BCW'(1);
            cnt    <= cnt_next;
          end
          if (frame_end) begin
            gnt       <= '0;
            done      <= 1'b1;
            done_ch   <= ch;
            match_cnt <= cnt_next;
            aborted   <= abort_now;
          end
        end
        S_DONE: begin
          rr_ptr <= (ch == LAST_CH) ? '0 : ch + CHW'(1);
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seqdet_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seqdet_frame_arbiter
// Purpose  : Directed self-checking bench for seqdet_frame_arbiter with the
//            default parameters (NCH=4, PATTERN=1001, FRAME_LEN=16, CNTW=5)
//            and SEQDET_TIMEOUT_EN undefined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seqdet_frame_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] din_valid;
  logic [3:0] gnt;
  logic       busy;
  logic       match;
  logic       done;
  logic [1:0] done_ch;
  logic [4:0] match_cnt;
  logic       aborted;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mm;
  logic [5:0]  b6;
  logic [2:0]  b3;

  seqdet_frame_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .din_valid (din_valid),
    .gnt       (gnt),
    .busy      (busy),
    .match     (match),
    .done      (done),
    .done_ch   (done_ch),
    .match_cnt (match_cnt),
    .aborted   (aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    return 4'(1 << c);
  endfunction

  // IDLE -> GRANT -> RUN for channel c
  task automatic start_frame(input int c);
    tick();
    chk("gnt_grant", gnt, oh(c));
    chk("busy_grant", busy, 1);
    tick();
    chk("gnt_run", gnt, oh(c));
  endtask

  // One valid bit on channel c; other channels carry inverted data
  task automatic send_bit(input int c, input logic b);
    din_valid = 4'hF;
    din       = b ? oh(c) : ~oh(c);
    tick();
    din_valid = 4'h0;
    din       = 4'h0;
  endtask

  // Full 16-bit frame; gap idle cycles (other channels valid) before each bit.
  // mask[i] is the match output right after bit i+1 was accepted.
  task automatic run_frame(input int c, input logic [15:0] bits, input int gap,
                           output logic [15:0] mask);
    mask = '0;
    start_frame(c);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        din_valid = ~oh(c);
        din       = 4'hF;
        tick();
        chk("match_gap", match, 0);
      end
      send_bit(c, bits[15-i]);
      mask[i] = match;
      if (i < 15) begin
        chk("done_early", done, 0);
        chk("gnt_held", gnt, oh(c));
      end
    end
    chk("done", done, 1);
    chk("gnt_done", gnt, 0);
    chk("busy_done", busy, 1);
  endtask

  task automatic to_idle();
    tick();
    chk("busy_idle", busy, 0);
    chk("gnt_idle", gnt, 0);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    rst       = 1'b0;
    req       = 4'h0;
    din       = 4'h0;
    din_valid = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    chk("rst_done_ch", done_ch, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_aborted", aborted, 0);
    rst = 1'b1;

    // Asynchronous reset in the middle of a ch1 frame, 5 bits in
    req = 4'b0010;
    start_frame(1);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    send_bit(1, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_match", match, 0);
    #1;
    rst = 1'b1;
    // Pointer back at 0: ch2 wins over ch3
    req = 4'b1100;
    start_frame(2);
    req = 4'b0000;
    tick();
    chk("t1_done", done, 1);
    chk("t1_aborted", aborted, 1);
    chk("t1_done_ch", done_ch, 2);
    chk("t1_match_cnt", match_cnt, 0);
    to_idle();

    // ch0 streams 1001001000000000 with continuous valid
    req = 4'b0001;
    run_frame(0, 16'b1001_0010_0000_0000, 0, mm);
    req = 4'b0000;
    chk("t2_match_pos", mm, 16'h0048);
    chk("t2_done_ch", done_ch, 0);
    chk("t2_match_cnt", match_cnt, 2);
    chk("t2_aborted", aborted, 0);
    to_idle();

    // ch3 streams 1001 x4 with valid every other cycle
    req = 4'b1000;
    run_frame(3, 16'h9999, 1, mm);
    req = 4'b0000;
    chk("t4_match_pos", mm, 16'h8888);
    chk("t4_match_last", match, 1);
    chk("t4_done_ch", done_ch, 3);
    chk("t4_match_cnt", match_cnt, 4);
    chk("t4_aborted", aborted, 0);
    to_idle();

    // 1001 split across two frames: ...100 | 1... must not match
    req = 4'b1000;
    run_frame(3, 16'h0004, 0, mm);
    chk("t4x_mask_a", mm, 16'h0000);
    chk("t4x_cnt_a", match_cnt, 0);
    to_idle();
    run_frame(3, 16'h8000, 0, mm);
    req = 4'b0000;
    chk("t4x_mask_b", mm, 16'h0000);
    chk("t4x_cnt_b", match_cnt, 0);
    to_idle();

    // All four requesting: grants 0,1,2,3,0 with one IDLE cycle between
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_frame(k % 4, 16'h9249, 0, mm);
      chk("t3_done_ch", done_ch, 32'(k % 4));
      chk("t3_match_cnt", match_cnt, 5);
      chk("t3_match_pos", mm, 16'h9248);
      if (k == 4) begin
        req = 4'b0000;
      end
      to_idle();
    end

    // ch2 drops req after 6 bits (100100)
    req = 4'b0100;
    start_frame(2);
    b6 = 6'b100100;
    for (int i = 0; i < 6; i++) begin
      send_bit(2, b6[5-i]);
    end
    req = 4'b0000;
    tick();
    chk("t5_done", done, 1);
    chk("t5_aborted", aborted, 1);
    chk("t5_done_ch", done_ch, 2);
    chk("t5_match_cnt", match_cnt, 1);
    chk("t5_match", match, 0);
    to_idle();

    // req drop in the same cycle as the bit completing 1001: bit still counts
    req = 4'b0100;
    start_frame(2);
    b3 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      send_bit(2, b3[2-i]);
    end
    req = 4'b0000;
    send_bit(2, 1'b1);
    chk("t5b_done", done, 1);
    chk("t5b_aborted", aborted, 1);
    chk("t5b_match", match, 1);
    chk("t5b_match_cnt", match_cnt, 1);
    to_idle();

    // ch1 stalls after 3 bits: without the timeout the grant is held
    req = 4'b0010;
    start_frame(1);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    din_valid = 4'b1101;
    din       = 4'hF;
    repeat (20) tick();
    chk("t6_gnt_held", gnt, 4'b0010);
    chk("t6_busy", busy, 1);
    chk("t6_no_done", done, 0);
    din_valid = 4'h0;
    din       = 4'h0;
    req       = 4'b0000;
    tick();
    chk("t6_done", done, 1);
    chk("t6_aborted", aborted, 1);
    chk("t6_done_ch", done_ch, 1);
    chk("t6_match_cnt", match_cnt, 0);
    to_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
